mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer between the multi-cycle datapath and the single-port, word-addressed unified memory.
//  Accepts byte/half/word requests on byte addresses and generates the memory address and enable strobes.
//  Memory reads are combinational and writes commit on posedge clk.
//  Sub-word stores run as read-modify-write. Loads are sign/zero-extended. Misaligned requests are rejected.
// PARAMETERS
//  WORD_LEN  32  data width; must be 32
//  ADDR_LEN  32  byte-address width of requests and of the memory address bus
// PORTS
//  clk          in   1         single clock, all state on posedge
//  rst_n        in   1         asynchronous, active-low reset
//  req_valid    in   1         request present
//  req_ready    out  1         unit idle, request accepted when valid&ready
//  req_we       in   1         1 = store, 0 = load
//  req_size     in   2         00 byte, 01 half, 10 word, 11 illegal
//  req_signed   in   1         loads: 1 = sign-extend, 0 = zero-extend
//  req_addr     in   ADDR_LEN  byte address
//  req_wdata    in   WORD_LEN  store data, right-aligned
//  resp_valid   out  1         one-cycle completion pulse
//  resp_err     out  1         qualifies resp_valid: misaligned or illegal size
//  resp_rdata   out  WORD_LEN  extended load data; 0 for stores and errors
//  mem_address  out  ADDR_LEN  word index = captured req_addr >> 2
//  mem_write_bus out WORD_LEN  word written to memory
//  mem_write_en out  1         memory write strobe
//  mem_read_en  out  1         memory read enable
//  mem_out_bus  in   WORD_LEN  combinational memory read data
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all registers cleared.
//    Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write_en=0, mem_read_en=0, mem_address=0, mem_write_bus=0.
//    Reset during any state aborts the operation immediately. No write is committed on a later edge.
//  - States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP. Strobes decode from the registered state only. Nothing passes combinationally from req_* to mem_*.
//  - IDLE: req_ready=1. On valid&ready, capture we/size/signed/addr/wdata and choose the next state:
//    - size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with err=1. No memory access.
//    - load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
//  - LOAD: mem_read_en=1. Extract the lane at addr[1:0] (little-endian), extend it, register it into resp_rdata, then -> RESP.
//  - STORE: mem_write_en=1, mem_write_bus=wdata -> RESP.
//  - RMW_RD: mem_read_en=1. Register mem_out_bus with the selected byte/half lane replaced by wdata[7:0]/[15:0] -> RMW_WR.
//  - RMW_WR: mem_write_en=1, mem_write_bus=merged word -> RESP.
//  - RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE.
//    resp_rdata holds until the next accepted load. Stores and errors clear it to 0.
//  - Latency from accept edge to resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
//  - req_ready=0 in every non-IDLE state. req_valid there is ignored and is not queued.
//  - mem_read_en and mem_write_en are never asserted together. mem_address is stable for the whole operation.
//  - Address wrap: mem_address is the plain truncating shift; no bounds check.
// STRUCTURE
//  - Shared package mem_access_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL encodings, state enum localparams, WORD_LEN default.
//  - One sub-module, lsu_align (pure combinational), provides two functions:
//    - load extract/extend (word, offset, size, signed -> data)
//    - store merge (old word, wdata, offset, size -> word)
//  - The top level holds the FSM and the capture registers.
// TESTING (bench pairs the unit with the memory model, preloaded 0x000: 0x8070_F0FF)
//  1. LB signed @0x000 -> rdata 0xFFFF_FFFF; LBU @0x001 -> 0x0000_00F0; 2 cycles each.
//  2. LH signed @0x002 -> 0xFFFF_8070; LH @0x001 -> resp_err=1 after 1 cycle, no mem_read_en/mem_write_en.
//  3. SB 0xAB @0x002 -> exactly one write, word 0 = 0x80AB_F0FF, resp after 3 cycles; then LW @0 returns 0x80AB_F0FF.
//  4. SW 0x1234_5678 @0x004 -> one write to mem_address 1, 2-cycle latency; SW @0x006 -> err, memory unchanged.
//  5. Back-to-back req_valid held high: second request accepted only on the IDLE cycle after RESP. No request is lost or duplicated.
//  6. Assert rst_n=0 during RMW_RD of SH @0x000 -> no write occurs; memory unchanged. All outputs read reset values while rst_n=0.
//     After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings, FSM states and alignment helper for the load/store unit
package mem_access_pkg;
   localparam int WORD_LEN_DEF = 32;
   typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10, SIZE_ILL = 2'b11} size_e;
   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_RMW_RD, ST_RMW_WR, ST_RESP} state_e;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return (size == SIZE_ILL) || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
   import mem_access_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_word
);
   logic [4:0]  w_sh;
   logic [31:0] w_lane;
   logic [31:0] w_mask;
   assign w_sh = {i_offset, 3'b000};
   assign w_lane = i_word >> w_sh;
   assign w_mask = (i_size == SIZE_BYTE) ? (32'h0000_00FF << w_sh) : (32'h0000_FFFF << w_sh);
   assign o_load_data = (i_size == SIZE_BYTE) ? {{24{i_signed & w_lane[7]}}, w_lane[7:0]} :
                        (i_size == SIZE_HALF) ? {{16{i_signed & w_lane[15]}}, w_lane[15:0]} : i_word;
   assign o_merge_word = (i_size == SIZE_WORD) ? i_wdata : (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer for a single-port word-addressed memory,
// with read-modify-write for sub-word stores and rejection of misaligned requests
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int WORD_LEN = WORD_LEN_DEF,
   parameter int ADDR_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic                i_req_we,
   input  logic [1:0]          i_req_size,
   input  logic                i_req_signed,
   input  logic [ADDR_LEN-1:0] i_req_addr,
   input  logic [WORD_LEN-1:0] i_req_wdata,
   output logic                o_resp_valid,
   output logic                o_resp_err,
   output logic [WORD_LEN-1:0] o_resp_rdata,
   output logic [ADDR_LEN-1:0] o_mem_address,
   output logic [WORD_LEN-1:0] o_mem_write_bus,
   output logic                o_mem_write_en,
   output logic                o_mem_read_en,
   input  logic [WORD_LEN-1:0] i_mem_out_bus
);
   state_e              r_state;
   state_e              w_next;
   logic [1:0]          r_size;
   logic                r_signed;
   logic                r_err;
   logic [ADDR_LEN-1:0] r_addr;
   logic [WORD_LEN-1:0] r_wdata;
   logic [WORD_LEN-1:0] r_merge;
   logic [WORD_LEN-1:0] r_rdata;
   logic [WORD_LEN-1:0] w_load_data;
   logic [WORD_LEN-1:0] w_merge;
   logic                w_accept;
   logic                w_bad;
   assign w_accept = i_req_valid && r_state == ST_IDLE;
   assign w_bad = misaligned(i_req_size, i_req_addr[1:0]);
   lsu_align u_align (
      .i_word       (i_mem_out_bus),
      .i_wdata      (r_wdata),
      .i_offset     (r_addr[1:0]),
      .i_size       (r_size),
      .i_signed     (r_signed),
      .o_load_data  (w_load_data),
      .o_merge_word (w_merge)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   w_next = !w_accept ? ST_IDLE : w_bad ? ST_RESP : !i_req_we ? ST_LOAD :
                             (i_req_size == SIZE_WORD) ? ST_STORE : ST_RMW_RD;
         ST_LOAD:   w_next = ST_RESP;
         ST_STORE:  w_next = ST_RESP;
         ST_RMW_RD: w_next = ST_RMW_WR;
         ST_RMW_WR: w_next = ST_RESP;
         default:   w_next = ST_IDLE;
      endcase
   end
   // Capture registers hold the request for the whole operation, keeping mem_address stable.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_size   <= '0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_merge  <= '0;
         r_rdata  <= '0;
      end else begin
         if (w_accept) begin
            r_size   <= i_req_size;
            r_signed <= i_req_signed;
            r_err    <= w_bad;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            if (i_req_we || w_bad) r_rdata <= '0;
         end
         if (r_state == ST_LOAD) r_rdata <= w_load_data;
         if (r_state == ST_RMW_RD) r_merge <= w_merge;
      end
   always_comb begin
      o_req_ready     = r_state == ST_IDLE;
      o_resp_valid    = r_state == ST_RESP;
      o_resp_err      = r_state == ST_RESP && r_err;
      o_resp_rdata    = r_rdata;
      o_mem_address   = r_addr >> 2;
      o_mem_read_en   = r_state == ST_LOAD || r_state == ST_RMW_RD;
      o_mem_write_en  = r_state == ST_STORE || r_state == ST_RMW_WR;
      o_mem_write_bus = (r_state == ST_STORE) ? r_wdata : (r_state == ST_RMW_WR) ? r_merge : '0;
   end
endmodule
